// File: rtl/memsys.sv
// Instruction and data memories for the 16-bit CPU with a byte-stream loader
// that fills or dumps either memory while the CPU is halted.
`timescale 1ns/1ps
module memsys #(
  parameter int unsigned AW = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] imem_addr,
  output logic [15:0] imem_rdata,
  input  logic [15:0] dmem_addr,
  output logic [15:0] dmem_rdata,
  input  logic [15:0] dmem_wdata,
  input  logic        dmem_write,
  input  logic        cpu_running,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        ld_busy,
  output logic        ld_err
);

  localparam int unsigned DEPTH = 1 << AW;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_CNT, S_WHI, S_WLO, S_RHI, S_RLO
  } state_t;

  logic [15:0] imem [DEPTH];
  logic [15:0] dmem [DEPTH];

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [8:0]    rem_q, rem_d;
  logic [7:0]    hi_q, hi_d;
  logic          tgt_dmem_q, tgt_dmem_d;
  logic          op_dump_q, op_dump_d;
  logic          err_q, err_d;
  logic          ld_we;
  logic          accept;
  logic [15:0]   rd_word;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^{imem_addr[15:AW], dmem_addr[15:AW]};

  assign imem_rdata = imem[imem_addr[AW-1:0]];
  assign dmem_rdata = dmem[dmem_addr[AW-1:0]];
  assign rd_word    = tgt_dmem_q ? dmem[ptr_q] : imem[ptr_q];

  assign in_ready = !cpu_running &&
                    (state_q inside {S_IDLE, S_ADDR, S_CNT, S_WHI, S_WLO});
  assign accept   = in_valid && in_ready;
  assign ld_busy  = (state_q != S_IDLE);
  assign ld_err   = err_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      rem_q      <= '0;
      hi_q       <= '0;
      tgt_dmem_q <= 1'b0;
      op_dump_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rem_q      <= rem_d;
      hi_q       <= hi_d;
      tgt_dmem_q <= tgt_dmem_d;
      op_dump_q  <= op_dump_d;
      err_q      <= err_d;
    end
  end

  // Frame parser: CMD, ADDR, CNT, then write words or dump words.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    rem_d      = rem_q;
    hi_d       = hi_q;
    tgt_dmem_d = tgt_dmem_q;
    op_dump_d  = op_dump_q;
    err_d      = err_q;
    ld_we      = 1'b0;
    out_valid  = 1'b0;
    out_data   = 8'h00;
    case (state_q)
      S_IDLE: if (accept) begin
        if (|in_data[5:0]) begin
          err_d = 1'b1;
        end else begin
          tgt_dmem_d = in_data[7];
          op_dump_d  = in_data[6];
          state_d    = S_ADDR;
        end
      end
      S_ADDR: if (accept) begin
        ptr_d   = in_data[AW-1:0];
        state_d = S_CNT;
      end
      S_CNT: if (accept) begin
        rem_d   = (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
        state_d = op_dump_q ? S_RHI : S_WHI;
      end
      S_WHI: if (accept) begin
        hi_d    = in_data;
        state_d = S_WLO;
      end
      S_WLO: if (accept) begin
        ld_we   = 1'b1;
        ptr_d   = ptr_q + AW'(1);
        rem_d   = rem_q - 9'd1;
        state_d = (rem_q == 9'd1) ? S_IDLE : S_WHI;
      end
      S_RHI: begin
        out_valid = 1'b1;
        out_data  = rd_word[15:8];
        if (out_ready) state_d = S_RLO;
      end
      S_RLO: begin
        out_valid = 1'b1;
        out_data  = rd_word[7:0];
        if (out_ready) begin
          ptr_d   = ptr_q + AW'(1);
          rem_d   = rem_q - 9'd1;
          state_d = (rem_q == 9'd1) ? S_IDLE : S_RHI;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // CPU start mid-frame aborts the frame; any half-received word is dropped.
    if (cpu_running && state_q != S_IDLE) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
      ld_we   = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (ld_we && !tgt_dmem_q) imem[ptr_q] <= {hi_q, in_data};
  end

  // CPU store is ordered last so it wins a same-word collision with the loader.
  always_ff @(posedge CLK) begin
    if (ld_we && tgt_dmem_q) dmem[ptr_q] <= {hi_q, in_data};
    if (dmem_write) dmem[dmem_addr[AW-1:0]] <= dmem_wdata;
  end

endmodule

// File: tb/tb_memsys.sv
// Directed self-checking bench for memsys: load, dump, wrap, abort, bad CMD
// and CPU-store priority.
`timescale 1ns/1ps
module tb_memsys;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] imem_addr, imem_rdata, dmem_addr, dmem_rdata, dmem_wdata;
  logic        dmem_write, cpu_running, in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  in_data, out_data;
  logic        ld_busy, ld_err;

  int errors = 0;
  int checks = 0;

  memsys #(.AW(8)) dut (
    .CLK(CLK), .RST(RST),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .dmem_addr(dmem_addr), .dmem_rdata(dmem_rdata),
    .dmem_wdata(dmem_wdata), .dmem_write(dmem_write),
    .cpu_running(cpu_running),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .ld_busy(ld_busy), .ld_err(ld_err)
  );

  always #5 CLK = ~CLK;

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 50) begin
      @(posedge CLK); #1;
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_byte_timeout byte=%h in_ready=%b required 1", b, in_ready);
    end else begin
      @(posedge CLK); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    RST = 1'b1;
    imem_addr = '0; dmem_addr = '0; dmem_wdata = '0; dmem_write = 1'b0;
    cpu_running = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checks++; if (ld_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", ld_busy); end
    checks++; if (ld_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", ld_err); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    cpu_running = 1'b1; #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_run got=%b exp=0", in_ready); end
    cpu_running = 1'b0;
    @(negedge CLK); RST = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_load;
    send_byte(8'h00); send_byte(8'h10); send_byte(8'h02);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'hAB);
    checks++; if (ld_busy !== 1'b1) begin errors++; $display("FAIL load_busy_mid got=%b exp=1", ld_busy); end
    send_byte(8'hCD);
    checks++; if (ld_busy !== 1'b0) begin errors++; $display("FAIL load_busy_end got=%b exp=0", ld_busy); end
    imem_addr = 16'h0010; #1;
    checks++; if (imem_rdata !== 16'h1234) begin errors++; $display("FAIL load_word0 got=%h exp=1234", imem_rdata); end
    imem_addr = 16'h0011; #1;
    checks++; if (imem_rdata !== 16'hABCD) begin errors++; $display("FAIL load_word1 got=%h exp=abcd", imem_rdata); end
    imem_addr = 16'hF710; #1;
    checks++; if (imem_rdata !== 16'h1234) begin errors++; $display("FAIL load_high_addr_ignored got=%h exp=1234", imem_rdata); end
    checks++; if (ld_err !== 1'b0) begin errors++; $display("FAIL load_err got=%b exp=0", ld_err); end
  endtask

  task automatic test_dump_backpressure;
    dmem_addr = 16'h0005; dmem_wdata = 16'hBEEF; dmem_write = 1'b1;
    @(posedge CLK); #1;
    dmem_write = 1'b0;
    send_byte(8'hC0); send_byte(8'h05); send_byte(8'h01);
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== 8'hBE) begin
        errors++; $display("FAIL dump_hold cyc=%0d got=%b/%h exp=1/be", i, out_valid, out_data);
      end
      @(posedge CLK); #1;
    end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL dump_in_ready got=%b exp=0", in_ready); end
    out_ready = 1'b1;
    @(posedge CLK); #1;
    checks++; if (out_valid !== 1'b1 || out_data !== 8'hEF) begin
      errors++; $display("FAIL dump_lo got=%b/%h exp=1/ef", out_valid, out_data);
    end
    @(posedge CLK); #1;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || ld_busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL dump_end got valid=%b busy=%b ready=%b exp 0/0/1", out_valid, ld_busy, in_ready);
    end
  endtask

  task automatic test_wrap_cnt0;
    logic [7:0]  idx;
    logic [15:0] exp;
    send_byte(8'h80); send_byte(8'hFF); send_byte(8'h00);
    for (int i = 0; i < 256; i++) begin
      idx = 8'(i);
      send_byte(idx);
      checks++; if (ld_busy !== 1'b1) begin errors++; $display("FAIL wrap_busy_mid word=%0d got=%b exp=1", i, ld_busy); end
      send_byte(~idx);
    end
    checks++; if (ld_busy !== 1'b0) begin errors++; $display("FAIL wrap_busy_end got=%b exp=0", ld_busy); end
    for (int a = 0; a < 256; a++) begin
      idx = 8'(a + 1);
      exp = {idx, ~idx};
      dmem_addr = 16'(a); #1;
      checks++; if (dmem_rdata !== exp) begin
        errors++; $display("FAIL wrap_word addr=%h got=%h exp=%h", a, dmem_rdata, exp);
      end
    end
  endtask

  task automatic test_abort;
    send_byte(8'h00); send_byte(8'h21); send_byte(8'h01); send_byte(8'h55); send_byte(8'h66);
    send_byte(8'h00); send_byte(8'h20); send_byte(8'h02);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    cpu_running = 1'b1;
    in_valid = 1'b1; in_data = 8'h44; #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL abort_in_ready got=%b exp=0", in_ready); end
    @(posedge CLK); #1;
    in_valid = 1'b0;
    checks++; if (ld_busy !== 1'b0 || ld_err !== 1'b1) begin
      errors++; $display("FAIL abort_state got busy=%b err=%b exp 0/1", ld_busy, ld_err);
    end
    imem_addr = 16'h0020; #1;
    checks++; if (imem_rdata !== 16'h1122) begin errors++; $display("FAIL abort_word1 got=%h exp=1122", imem_rdata); end
    imem_addr = 16'h0021; #1;
    checks++; if (imem_rdata !== 16'h5566) begin errors++; $display("FAIL abort_word2 got=%h exp=5566", imem_rdata); end
    @(posedge CLK); #1;
    checks++; if (in_ready !== 1'b0 || ld_err !== 1'b1) begin
      errors++; $display("FAIL abort_running got ready=%b err=%b exp 0/1", in_ready, ld_err);
    end
    cpu_running = 1'b0;
    RST = 1'b1; #1;
    checks++; if (ld_err !== 1'b0) begin errors++; $display("FAIL rst_clears_err got=%b exp=0", ld_err); end
    @(negedge CLK); RST = 1'b0;
    imem_addr = 16'h0020; #1;
    checks++; if (imem_rdata !== 16'h1122) begin errors++; $display("FAIL rst_keeps_mem got=%h exp=1122", imem_rdata); end
    @(posedge CLK); #1;
  endtask

  task automatic test_bad_cmd;
    send_byte(8'h01);
    checks++; if (ld_err !== 1'b1 || ld_busy !== 1'b0) begin
      errors++; $display("FAIL bad_cmd got err=%b busy=%b exp 1/0", ld_err, ld_busy);
    end
    send_byte(8'h80); send_byte(8'h30); send_byte(8'h01); send_byte(8'h77); send_byte(8'h88);
    dmem_addr = 16'h0030; #1;
    checks++; if (dmem_rdata !== 16'h7788 || ld_busy !== 1'b0) begin
      errors++; $display("FAIL bad_cmd_recover got=%h busy=%b exp 7788/0", dmem_rdata, ld_busy);
    end
  endtask

  task automatic test_store_priority;
    send_byte(8'h80); send_byte(8'h03); send_byte(8'h01); send_byte(8'h11);
    in_valid = 1'b1; in_data = 8'h11;
    dmem_write = 1'b1; dmem_addr = 16'h0003; dmem_wdata = 16'h2222;
    @(posedge CLK); #1;
    in_valid = 1'b0; dmem_write = 1'b0;
    checks++; if (dmem_rdata !== 16'h2222 || ld_busy !== 1'b0) begin
      errors++; $display("FAIL collision got=%h busy=%b exp 2222/0", dmem_rdata, ld_busy);
    end
    send_byte(8'h80); send_byte(8'h40); send_byte(8'h01); send_byte(8'hAA);
    in_valid = 1'b1; in_data = 8'hBB;
    dmem_write = 1'b1; dmem_addr = 16'h0041; dmem_wdata = 16'h5A5A;
    @(posedge CLK); #1;
    in_valid = 1'b0; dmem_write = 1'b0;
    checks++; if (dmem_rdata !== 16'h5A5A) begin errors++; $display("FAIL dual_cpu_word got=%h exp=5a5a", dmem_rdata); end
    dmem_addr = 16'h0040; #1;
    checks++; if (dmem_rdata !== 16'hAABB) begin errors++; $display("FAIL dual_loader_word got=%h exp=aabb", dmem_rdata); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_dump_backpressure();
    test_wrap_cnt0();
    test_abort();
    test_bad_cmd();
    test_store_priority();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
